// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 command decoder: opcodes, addressing
// modes, pointer-load encodings and the argument-count table.
package ssd1306_pkg;

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'b00,
    MODE_VERT  = 2'b01,
    MODE_PAGE  = 2'b10
  } addr_mode_e;

  typedef enum logic {
    ST_CMD,
    ST_ARG
  } dec_state_e;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_COL_LO,
    LD_COL_HI,
    LD_PAGE,
    LD_COL_START,
    LD_COL_END,
    LD_PAGE_START,
    LD_PAGE_END
  } ld_op_e;

  typedef struct packed {
    ld_op_e     op;
    logic [6:0] val;
  } addr_load_t;

  localparam logic [7:0] OP_SET_MODE   = 8'h20;
  localparam logic [7:0] OP_COL_ADDR   = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_REMAP_OFF  = 8'hA0;
  localparam logic [7:0] OP_REMAP_ON   = 8'hA1;
  localparam logic [7:0] OP_ALLON_OFF  = 8'hA4;
  localparam logic [7:0] OP_ALLON_ON   = 8'hA5;
  localparam logic [7:0] OP_INV_OFF    = 8'hA6;
  localparam logic [7:0] OP_INV_ON     = 8'hA7;
  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_COM_NORM   = 8'hC0;
  localparam logic [7:0] OP_COM_FLIP   = 8'hC8;

  localparam logic [7:0] CONTRAST_RST_DEF = 8'h7F;
  localparam logic [6:0] COL_MAX          = 7'd127;
  localparam logic [2:0] PAGE_MAX         = 3'd7;

  // Number of argument bytes that follow a multi-byte opcode; 0 means single-byte or unknown.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5,
      8'hD9, 8'hDA, 8'hDB, 8'h8D:         return 3'd1;
      8'h21, 8'h22, 8'hA3:                return 3'd2;
      8'h29, 8'h2A:                       return 3'd5;
      8'h26, 8'h27:                       return 3'd6;
      default:                            return 3'd0;
    endcase
  endfunction

  // The reserved mode encoding 2'b11 behaves as page addressing.
  function automatic addr_mode_e to_mode(input logic [1:0] m);
    case (m)
      2'b00:   return MODE_HORIZ;
      2'b01:   return MODE_VERT;
      default: return MODE_PAGE;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_cmd_decoder_if.sv
// Byte handshake from the SPI slave plus the framebuffer write port of the decoder.
interface ssd1306_cmd_decoder_if #(
  parameter int FB_AW = 10
);
  logic             rdy_i;
  logic [7:0]       byte_i;
  logic             byte_ack_o;
  logic             dc_i;
  logic             fb_we_o;
  logic [FB_AW-1:0] fb_addr_o;
  logic [7:0]       fb_data_o;

  modport master (
    output rdy_i, byte_i, dc_i,
    input  byte_ack_o, fb_we_o, fb_addr_o, fb_data_o
  );

  modport slave (
    input  rdy_i, byte_i, dc_i,
    output byte_ack_o, fb_we_o, fb_addr_o, fb_data_o
  );
endinterface

// File: rtl/ssd1306_addr_gen.sv
// Column/page write pointers and their ranges; loaded by decoded commands and
// stepped once per framebuffer write according to the addressing mode.
module ssd1306_addr_gen
  import ssd1306_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  addr_mode_e mode_i,
  input  addr_load_t load_i,
  input  logic       step_i,
  output logic [6:0] col_o,
  output logic [2:0] page_o
);

  logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;

  always_comb begin
    col_d        = col_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;

    // Increments are modulo the field width, so an inverted range still wraps without lock-up.
    if (step_i) begin
      case (mode_i)
        MODE_HORIZ: begin
          if (col_q == col_end_q) begin
            col_d  = col_start_q;
            page_d = (page_q == page_end_q) ? page_start_q : page_q + 3'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        MODE_VERT: begin
          if (page_q == page_end_q) begin
            page_d = page_start_q;
            col_d  = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
          end else begin
            page_d = page_q + 3'd1;
          end
        end
        default: col_d = col_q + 7'd1;
      endcase
    end

    case (load_i.op)
      LD_COL_LO:     col_d = {col_q[6:4], load_i.val[3:0]};
      LD_COL_HI:     col_d = {load_i.val[2:0], col_q[3:0]};
      LD_PAGE:       page_d = load_i.val[2:0];
      LD_COL_START: begin
        col_start_d = load_i.val;
        col_d       = load_i.val;
      end
      LD_COL_END:    col_end_d = load_i.val;
      LD_PAGE_START: begin
        page_start_d = load_i.val[2:0];
        page_d       = load_i.val[2:0];
      end
      LD_PAGE_END:   page_end_d = load_i.val[2:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q        <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= COL_MAX;
      page_start_q <= '0;
      page_end_q   <= PAGE_MAX;
    end else begin
      col_q        <= col_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign col_o  = col_q;
  assign page_o = page_q;

endmodule

// File: rtl/ssd1306_cmd_decoder.sv
// SSD1306 command/data decoder: accepts SPI bytes, runs the CMD/ARG state machine,
// holds display-control registers and issues framebuffer writes.
module ssd1306_cmd_decoder
  import ssd1306_pkg::*;
#(
  parameter int         FB_AW        = 10,
  parameter logic [7:0] CONTRAST_RST = CONTRAST_RST_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ssd1306_cmd_decoder_if.slave bus,
  output logic                 display_on_o,
  output logic                 invert_o,
  output logic                 all_on_o,
  output logic                 seg_remap_o,
  output logic                 com_flip_o,
  output logic [7:0]           contrast_o
);

  logic             dc_meta_q, dc_sync_q;
  logic             ack_q, ack_d, ack_dly_q, armed_q, armed_d;
  dec_state_e       state_q, state_d;
  logic [2:0]       arg_cnt_q, arg_cnt_d;
  logic [7:0]       opcode_q, opcode_d;
  logic             disp_q, disp_d, inv_q, inv_d, allon_q, allon_d;
  logic             remap_q, remap_d, flip_q, flip_d;
  logic [7:0]       contrast_q, contrast_d;
  addr_mode_e       mode_q, mode_d;
  logic             fb_we_q, fb_we_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]       fb_data_q, fb_data_d;

  logic       accept, step;
  addr_load_t load;
  logic [6:0] col;
  logic [2:0] page;

  // Blank covers the two cycles before the slave drops rdy_i; armed additionally
  // requires rdy_i to be seen low once, so a level held past the blank is not re-taken.
  assign accept = bus.rdy_i & armed_q & ~(ack_q | ack_dly_q);

  // NOTE: every _d and strobe gets its default first, so no path leaves a latch behind.
  always_comb begin
    ack_d      = accept;
    armed_d    = armed_q | ~bus.rdy_i;
    state_d    = state_q;
    arg_cnt_d  = arg_cnt_q;
    opcode_d   = opcode_q;
    disp_d     = disp_q;
    inv_d      = inv_q;
    allon_d    = allon_q;
    remap_d    = remap_q;
    flip_d     = flip_q;
    contrast_d = contrast_q;
    mode_d     = mode_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    step       = 1'b0;
    load.op    = LD_NONE;
    load.val   = '0;

    if (accept) begin
      armed_d = 1'b0;
      if (dc_sync_q) begin
        // Data aborts any pending multi-byte command.
        state_d   = ST_CMD;
        arg_cnt_d = '0;
        fb_we_d   = 1'b1;
        fb_addr_d = FB_AW'({page, col});
        fb_data_d = bus.byte_i;
        step      = 1'b1;
      end else if (state_q == ST_CMD) begin
        casez (bus.byte_i)
          8'b0000_????: begin
            load.op  = LD_COL_LO;
            load.val = {3'b000, bus.byte_i[3:0]};
          end
          8'b0001_????: begin
            load.op  = LD_COL_HI;
            load.val = {4'b0000, bus.byte_i[2:0]};
          end
          8'b1011_0???: begin
            load.op  = LD_PAGE;
            load.val = {4'b0000, bus.byte_i[2:0]};
          end
          OP_DISP_OFF, OP_DISP_ON:   disp_d  = bus.byte_i[0];
          OP_INV_OFF, OP_INV_ON:     inv_d   = bus.byte_i[0];
          OP_ALLON_OFF, OP_ALLON_ON: allon_d = bus.byte_i[0];
          OP_REMAP_OFF, OP_REMAP_ON: remap_d = bus.byte_i[0];
          OP_COM_NORM, OP_COM_FLIP:  flip_d  = bus.byte_i[3];
          default: begin
            if (arg_count(bus.byte_i) != 3'd0) begin
              state_d   = ST_ARG;
              arg_cnt_d = arg_count(bus.byte_i);
              opcode_d  = bus.byte_i;
            end
          end
        endcase
      end else begin
        arg_cnt_d = arg_cnt_q - 3'd1;
        if (arg_cnt_q == 3'd1) state_d = ST_CMD;
        case (opcode_q)
          OP_SET_MODE: mode_d     = to_mode(bus.byte_i[1:0]);
          OP_CONTRAST: contrast_d = bus.byte_i;
          OP_COL_ADDR: begin
            load.op  = (arg_cnt_q == 3'd2) ? LD_COL_START : LD_COL_END;
            load.val = bus.byte_i[6:0];
          end
          OP_PAGE_ADDR: begin
            load.op  = (arg_cnt_q == 3'd2) ? LD_PAGE_START : LD_PAGE_END;
            load.val = {4'b0000, bus.byte_i[2:0]};
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dc_meta_q  <= 1'b0;
      dc_sync_q  <= 1'b0;
      ack_q      <= 1'b0;
      ack_dly_q  <= 1'b0;
      armed_q    <= 1'b1;
      state_q    <= ST_CMD;
      arg_cnt_q  <= '0;
      opcode_q   <= '0;
      disp_q     <= 1'b0;
      inv_q      <= 1'b0;
      allon_q    <= 1'b0;
      remap_q    <= 1'b0;
      flip_q     <= 1'b0;
      contrast_q <= CONTRAST_RST;
      mode_q     <= MODE_PAGE;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      dc_meta_q  <= bus.dc_i;
      dc_sync_q  <= dc_meta_q;
      ack_q      <= ack_d;
      ack_dly_q  <= ack_q;
      armed_q    <= armed_d;
      state_q    <= state_d;
      arg_cnt_q  <= arg_cnt_d;
      opcode_q   <= opcode_d;
      disp_q     <= disp_d;
      inv_q      <= inv_d;
      allon_q    <= allon_d;
      remap_q    <= remap_d;
      flip_q     <= flip_d;
      contrast_q <= contrast_d;
      mode_q     <= mode_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  ssd1306_addr_gen u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .mode_i (mode_q),
    .load_i (load),
    .step_i (step),
    .col_o  (col),
    .page_o (page)
  );

  assign bus.byte_ack_o = ack_q;
  assign bus.fb_we_o    = fb_we_q;
  assign bus.fb_addr_o  = fb_addr_q;
  assign bus.fb_data_o  = fb_data_q;
  assign display_on_o   = disp_q;
  assign invert_o       = inv_q;
  assign all_on_o       = allon_q;
  assign seg_remap_o    = remap_q;
  assign com_flip_o     = flip_q;
  assign contrast_o     = contrast_q;

endmodule

// File: tb/tb_ssd1306_cmd_decoder.sv
// Directed bench for ssd1306_cmd_decoder: control commands, all addressing modes,
// handshake timing, argument abort and mid-command reset.
module tb_ssd1306_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       display_on, invert, all_on, seg_remap, com_flip;
  logic [7:0] contrast;

  int vectors     = 0;
  int miscompares = 0;
  int we_cnt      = 0;

  logic       got_ack, got_we;
  logic [9:0] got_addr;
  logic [7:0] got_data;

  always #5 clk = ~clk;

  ssd1306_cmd_decoder_if #(.FB_AW(10)) bus_if ();

  ssd1306_cmd_decoder #(.FB_AW(10), .CONTRAST_RST(8'h7F)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus_if),
    .display_on_o (display_on),
    .invert_o     (invert),
    .all_on_o     (all_on),
    .seg_remap_o  (seg_remap),
    .com_flip_o   (com_flip),
    .contrast_o   (contrast)
  );

  always @(negedge clk) if (bus_if.fb_we_o === 1'b1) we_cnt++;

  // One byte through the handshake; records what the decoder showed in the ack cycle.
  task automatic xfer(input logic dc, input logic [7:0] b);
    bus_if.dc_i   = dc;
    bus_if.byte_i = b;
    repeat (3) @(negedge clk);
    bus_if.rdy_i = 1'b1;
    got_ack  = 1'b0;
    got_we   = 1'bx;
    got_addr = 'x;
    got_data = 'x;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge clk);
      if (bus_if.byte_ack_o === 1'b1) begin
        got_ack  = 1'b1;
        got_we   = bus_if.fb_we_o;
        got_addr = bus_if.fb_addr_o;
        got_data = bus_if.fb_data_o;
      end
    end
    bus_if.rdy_i = 1'b0;
    vectors++;
    if (got_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_timeout byte=%h: no byte_ack_o within 8 cycles, expected one", b);
    end
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] b);
    xfer(1'b0, b);
    vectors++;
    if (got_we !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_no_write byte=%h: fb_we_o=%b, expected 0", b, got_we);
    end
  endtask

  task automatic dat(input logic [7:0] b, input logic [9:0] exp_addr);
    xfer(1'b1, b);
    vectors++;
    if (got_we !== 1'b1 || got_addr !== exp_addr || got_data !== b) begin
      miscompares++;
      $display("FAIL data_write: we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
               got_we, got_addr, got_data, exp_addr, b);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #3;
    vectors++;
    if ({display_on, invert, all_on, seg_remap, com_flip} !== 5'b0 || contrast !== 8'h7F) begin
      miscompares++;
      $display("FAIL reset_ctrl: disp/inv/allon/remap/flip=%b contrast=%h, expected 00000 7f",
               {display_on, invert, all_on, seg_remap, com_flip}, contrast);
    end
    vectors++;
    if (bus_if.fb_we_o !== 1'b0 || bus_if.byte_ack_o !== 1'b0 ||
        bus_if.fb_addr_o !== 10'h000 || bus_if.fb_data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bus: we=%b ack=%b addr=%h data=%h, expected 0 0 000 00",
               bus_if.fb_we_o, bus_if.byte_ack_o, bus_if.fb_addr_o, bus_if.fb_data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus_if.rdy_i  = 1'b0;
    bus_if.dc_i   = 1'b0;
    bus_if.byte_i = 8'h00;
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_ctrl();
    int we0;
    we0 = we_cnt;
    cmd(8'hAF); cmd(8'hA7); cmd(8'h81); cmd(8'h40);
    vectors++;
    if (display_on !== 1'b1 || invert !== 1'b1 || contrast !== 8'h40) begin
      miscompares++;
      $display("FAIL ctrl_set: disp=%b inv=%b contrast=%h, expected 1 1 40", display_on, invert, contrast);
    end
    cmd(8'hA5); cmd(8'hA1); cmd(8'hC8);
    vectors++;
    if ({all_on, seg_remap, com_flip} !== 3'b111) begin
      miscompares++;
      $display("FAIL ctrl_on: allon/remap/flip=%b, expected 111", {all_on, seg_remap, com_flip});
    end
    cmd(8'hA4); cmd(8'hA0); cmd(8'hC0); cmd(8'hE3);
    vectors++;
    if ({all_on, seg_remap, com_flip} !== 3'b000 || display_on !== 1'b1 || contrast !== 8'h40) begin
      miscompares++;
      $display("FAIL ctrl_off: allon/remap/flip=%b disp=%b contrast=%h, expected 000 1 40",
               {all_on, seg_remap, com_flip}, display_on, contrast);
    end
    @(negedge clk); #1;
    vectors++;
    if (we_cnt !== we0) begin
      miscompares++;
      $display("FAIL ctrl_no_writes: %0d fb_we_o pulses, expected 0", we_cnt - we0);
    end
  endtask

  task automatic test_horiz_full();
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h00); cmd(8'h7F);
    cmd(8'h22); cmd(8'h00); cmd(8'h07);
    for (int i = 0; i < 1025; i++) dat(8'(i), 10'(i % 1024));
  endtask

  task automatic test_vert();
    logic [9:0] exp_a [5] = '{10'h000, 10'h080, 10'h001, 10'h081, 10'h000};
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'h00); cmd(8'h01);
    cmd(8'h22); cmd(8'h00); cmd(8'h01);
    for (int i = 0; i < 5; i++) dat(8'(8'h11 * (i + 1)), exp_a[i]);
  endtask

  task automatic test_horiz_window();
    logic [9:0] exp_a [5] = '{10'h110, 10'h111, 10'h190, 10'h191, 10'h110};
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'h10); cmd(8'h11);
    cmd(8'h22); cmd(8'h02); cmd(8'h03);
    for (int i = 0; i < 5; i++) dat(8'(8'hA0 + i), exp_a[i]);
  endtask

  task automatic test_page_mode();
    cmd(8'h20); cmd(8'h02);
    cmd(8'hB3); cmd(8'h05); cmd(8'h12);
    dat(8'h01, 10'h1A5);
    dat(8'h02, 10'h1A6);
    cmd(8'h0F); cmd(8'h17);
    dat(8'h03, 10'h1FF);
    dat(8'h04, 10'h180);
  endtask

  task automatic test_handshake();
    int         n_ack, n_we;
    logic [9:0] w_addr;
    logic [7:0] w_data;
    n_ack = 0; n_we = 0; w_addr = 'x; w_data = 'x;
    bus_if.dc_i   = 1'b1;
    bus_if.byte_i = 8'h3C;
    repeat (3) @(negedge clk);
    bus_if.rdy_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.byte_ack_o === 1'b1) n_ack++;
      if (bus_if.fb_we_o === 1'b1) begin
        n_we++;
        w_addr = bus_if.fb_addr_o;
        w_data = bus_if.fb_data_o;
      end
    end
    bus_if.rdy_i = 1'b0;
    vectors++;
    if (n_ack !== 1 || n_we !== 1 || w_addr !== 10'h181 || w_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL held_rdy: acks=%0d writes=%0d addr=%h data=%h, expected 1 1 181 3c",
               n_ack, n_we, w_addr, w_data);
    end

    // Re-assert in the blank window, then keep it up into T+3.
    bus_if.byte_i = 8'h5A;
    repeat (2) @(negedge clk);
    bus_if.rdy_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus_if.byte_ack_o !== 1'b1 || bus_if.fb_addr_o !== 10'h182 || bus_if.fb_data_o !== 8'h5A) begin
      miscompares++;
      $display("FAIL first_accept: ack=%b addr=%h data=%h, expected 1 182 5a",
               bus_if.byte_ack_o, bus_if.fb_addr_o, bus_if.fb_data_o);
    end
    bus_if.rdy_i = 1'b0;
    @(negedge clk);
    bus_if.rdy_i  = 1'b1;
    bus_if.byte_i = 8'h6B;
    @(negedge clk);
    vectors++;
    if (bus_if.byte_ack_o !== 1'b0 || bus_if.fb_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_t2: ack=%b we=%b, expected 0 0", bus_if.byte_ack_o, bus_if.fb_we_o);
    end
    @(negedge clk);
    vectors++;
    if (bus_if.byte_ack_o !== 1'b1 || bus_if.fb_we_o !== 1'b1 ||
        bus_if.fb_addr_o !== 10'h183 || bus_if.fb_data_o !== 8'h6B) begin
      miscompares++;
      $display("FAIL accept_t3: ack=%b we=%b addr=%h data=%h, expected 1 1 183 6b",
               bus_if.byte_ack_o, bus_if.fb_we_o, bus_if.fb_addr_o, bus_if.fb_data_o);
    end
    bus_if.rdy_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_arg_abort();
    cmd(8'h26); cmd(8'h00); cmd(8'h00); cmd(8'h00);
    dat(8'h99, 10'h184);
    cmd(8'hAE);
    vectors++;
    if (display_on !== 1'b0) begin
      miscompares++;
      $display("FAIL arg_abort: display_on=%b after AE, expected 0", display_on);
    end
  endtask

  task automatic test_reset_mid_cmd();
    cmd(8'hAF);
    cmd(8'h81);
    @(negedge clk);
    apply_reset();
    cmd(8'hAF);
    vectors++;
    if (display_on !== 1'b1 || contrast !== 8'h7F) begin
      miscompares++;
      $display("FAIL reset_mid_cmd: disp=%b contrast=%h, expected 1 7f", display_on, contrast);
    end
    cmd(8'h0F); cmd(8'h17);
    dat(8'hC3, 10'h07F);
    dat(8'h3C, 10'h000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    test_reset();
    test_ctrl();
    test_horiz_full();
    test_vert();
    test_horiz_window();
    test_page_mode();
    test_handshake();
    test_arg_abort();
    test_reset_mid_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
